// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, opcodes and FSM state encoding for the accumulator CPU
package cpu_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] DIV_ZERO_VAL = 16'hFFFF;
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_NOT   = 4'h7;
  localparam logic [3:0] OP_JUMP  = 4'h8;
  localparam logic [3:0] OP_JZ    = 4'h9;
  localparam logic [3:0] OP_DIV   = 4'hA;
  localparam logic [3:0] OP_HALT  = 4'hF;
  typedef enum logic [2:0] {
    FETCH_A, FETCH_D, DECODE, OP_A, OP_D, EXECUTE, DIV_WAIT, HALT
  } state_t;
endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational result and zero flag for LOAD/ADD/SUB/AND/OR/NOT
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] mdr,
  output logic [DATA_W-1:0] result,
  output logic              zero
);
  always_comb begin
    result = op == OP_LOAD ? mdr :
             op == OP_ADD  ? acc + mdr :
             op == OP_SUB  ? acc - mdr :
             op == OP_AND  ? acc & mdr :
             op == OP_OR   ? acc | mdr :
             op == OP_NOT  ? ~acc : acc;
    zero = result == '0;
  end
endmodule

// File: rtl/cpu_controller.sv
// cpu_controller: multicycle accumulator CPU controller; CPU_DIV_EN builds the DIV handshake
module cpu_controller
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              Reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              div_load,
  output logic [DATA_W-1:0] div_a,
  output logic [DATA_W-1:0] div_b,
  input  logic [DATA_W-1:0] div_q,
  input  logic              div_done,
  output logic              halted,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] acc,
  output logic              zflag
);
  state_t state, state_n;
  logic [ADDR_W-1:0] pc_n, opa;
  logic [DATA_W-1:0] ir_n, acc_n, mdr, mdr_n, alu_res;
  logic [3:0] op;
  logic z_n, alu_zero;
  assign op = ir[15:12];
  assign opa = ir[7:0];
  assign mem_wdata = acc;
  assign halted = state == HALT;
  cpu_alu u_alu (.op(op), .acc(acc), .mdr(mdr), .result(alu_res), .zero(alu_zero));
`ifdef CPU_DIV_EN
  logic first, first_n, dz;
  assign dz = mdr == '0;
  assign div_a = acc;
  assign div_b = mdr;
`else
  logic unused_div;
  assign unused_div = ^{div_q, div_done};
  assign div_load = 1'b0;
  assign div_a = '0;
  assign div_b = '0;
`endif
  always_comb begin
    state_n = state;
    pc_n = pc;
    ir_n = ir;
    acc_n = acc;
    mdr_n = mdr;
    z_n = zflag;
    mem_addr = pc;
    mem_we = 1'b0;
`ifdef CPU_DIV_EN
    div_load = 1'b0;
    first_n = 1'b0;
`endif
    case (state)
      FETCH_A: state_n = FETCH_D;
      FETCH_D: begin
        ir_n = mem_rdata;
        pc_n = pc + 8'd1;
        state_n = DECODE;
      end
      DECODE: begin
        state_n = FETCH_A;
        case (op)
          OP_NOT: begin
            acc_n = alu_res;
            z_n = alu_zero;
          end
          OP_JUMP: pc_n = opa;
          OP_JZ: pc_n = zflag ? opa : pc;
          OP_STORE: begin
            mem_addr = opa;
            mem_we = 1'b1;
          end
          OP_HALT: state_n = HALT;
          OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR: state_n = OP_A;
`ifdef CPU_DIV_EN
          OP_DIV: state_n = OP_A;
`endif
          default: ;
        endcase
      end
      OP_A: begin
        mem_addr = opa;
        state_n = OP_D;
      end
      OP_D: begin
        mem_addr = opa;
        mdr_n = mem_rdata;
        state_n = EXECUTE;
      end
      EXECUTE: begin
        state_n = FETCH_A;
        acc_n = alu_res;
        z_n = alu_zero;
`ifdef CPU_DIV_EN
        if (op == OP_DIV) begin
          acc_n = dz ? DIV_ZERO_VAL : acc;
          z_n = dz ? 1'b0 : zflag;
          div_load = !dz;
          first_n = !dz;
          state_n = dz ? FETCH_A : DIV_WAIT;
        end
`endif
      end
`ifdef CPU_DIV_EN
      // The divider's Done is still high from the last division on the first wait cycle
      DIV_WAIT: if (!first && div_done) begin
        acc_n = div_q;
        z_n = div_q == '0;
        state_n = FETCH_A;
      end
`endif
      HALT: ;
      default: state_n = FETCH_A;
    endcase
  end
  always_ff @(posedge clk) begin
    if (Reset) begin
      state <= FETCH_A;
      pc <= '0;
      ir <= '0;
      acc <= '0;
      mdr <= '0;
      zflag <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      ir <= ir_n;
      acc <= acc_n;
      mdr <= mdr_n;
      zflag <= z_n;
    end
  end
`ifdef CPU_DIV_EN
  always_ff @(posedge clk) first <= Reset ? 1'b0 : first_n;
`endif
endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: directed programs against a sync-read RAM and a 4-cycle divider model
module tb_cpu_controller;
  logic clk = 1'b0;
  logic Reset = 1'b1;
  logic [7:0] mem_addr, pc;
  logic mem_we, div_load, halted, zflag;
  logic [15:0] mem_wdata, mem_rdata, div_a, div_b, ir, acc;
  logic [15:0] div_q = 16'h1234;
  logic div_done = 1'b1;
  logic [15:0] mem [256];
  logic tb_we = 1'b0;
  logic [7:0] tb_addr = '0;
  logic [15:0] tb_data = '0;
  logic [15:0] da, db;
  int cnt = 0;
  int loads = 0;
  int checks = 0;
  int failures = 0;
  int l0;

  cpu_controller dut (
    .clk(clk), .Reset(Reset), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .div_load(div_load),
    .div_a(div_a), .div_b(div_b), .div_q(div_q), .div_done(div_done),
    .halted(halted), .pc(pc), .ir(ir), .acc(acc), .zflag(zflag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tb_we) mem[tb_addr] <= tb_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  always @(posedge clk) begin
    if (div_load) loads <= loads + 1;
    if (Reset) cnt <= 0;
    else if (div_load) begin
      cnt <= 4;
      div_done <= 1'b0;
      da <= div_a;
      db <= div_b;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        div_done <= 1'b1;
        div_q <= da / db;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    tb_we = 1'b1;
    tb_addr = a;
    tb_data = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic go();
    Reset = 1'b0;
    check("start_addr", mem_addr, 8'h00);
  endtask

  task automatic wait_halt(input int lim);
    for (int i = 0; i < lim && !halted; i++) step(1);
    check("halt_reached", halted, 1);
  endtask

  initial begin
    step(2);
    check("rst_pc", pc, 8'h00);
    check("rst_ir", ir, 16'h0000);
    check("rst_acc", acc, 16'h0000);
    check("rst_z", zflag, 0);
    check("rst_halted", halted, 0);
    check("rst_we", mem_we, 0);
    check("rst_divload", div_load, 0);

    wr(8'h00, 16'h1010); wr(8'h01, 16'h3011); wr(8'h02, 16'h2012); wr(8'h03, 16'hF000);
    wr(8'h10, 16'h0005); wr(8'h11, 16'h0003); wr(8'h12, 16'h0000);
    go();
    step(17);
    check("t1_not_yet_halted", halted, 0);
    step(1);
    check("t1_halted_c18", halted, 1);
    check("t1_acc", acc, 16'h0008);
    check("t1_pc", pc, 8'h04);
    check("t1_mem12", mem[8'h12], 16'h0008);
    check("t1_halt_addr", mem_addr, 8'h04);
    step(3);
    check("t1_stays_halted", halted, 1);
    check("t1_halt_we", mem_we, 0);

    Reset = 1'b1;
    wr(8'h00, 16'h1040); wr(8'h01, 16'h3041); wr(8'h02, 16'h6042); wr(8'h03, 16'h5043);
    wr(8'h04, 16'h7000); wr(8'h05, 16'h2044); wr(8'h06, 16'h7000); wr(8'h07, 16'hB000);
    wr(8'h08, 16'h1044); wr(8'h09, 16'h4045); wr(8'h0A, 16'hF000);
    wr(8'h40, 16'hFFFF); wr(8'h41, 16'h0001); wr(8'h42, 16'h00F0); wr(8'h43, 16'h0030);
    wr(8'h44, 16'h0000); wr(8'h45, 16'hFFD0);
    go();
    step(6);  check("a_load", acc, 16'hFFFF); check("a_load_z", zflag, 0);
    step(6);  check("a_add_wrap", acc, 16'h0000); check("a_add_z", zflag, 1);
    step(6);  check("a_or", acc, 16'h00F0); check("a_or_z", zflag, 0);
    step(6);  check("a_and", acc, 16'h0030);
    step(3);  check("a_not", acc, 16'hFFCF);
    step(2);  check("a_store_we", mem_we, 1); check("a_store_addr", mem_addr, 8'h44);
    step(1);  check("a_mem44", mem[8'h44], 16'hFFCF); check("a_we_low", mem_we, 0);
    step(3);  check("a_not2", acc, 16'h0030);
    step(3);  check("a_nop_b", acc, 16'h0030); check("a_nop_pc", pc, 8'h08);
    step(6);  check("a_load_after_store", acc, 16'hFFCF);
    step(6);  check("a_sub_borrow", acc, 16'hFFFF); check("a_sub_z", zflag, 0);
    step(3);  check("a_halted", halted, 1);

    Reset = 1'b1;
    wr(8'h00, 16'h1020); wr(8'h01, 16'h4021); wr(8'h02, 16'h9030); wr(8'h03, 16'hF000);
    wr(8'h20, 16'h0003); wr(8'h21, 16'h0003); wr(8'h22, 16'h0001); wr(8'h30, 16'hF000);
    go();
    step(12); check("b_sub_zero", acc, 16'h0000); check("b_z1", zflag, 1);
    step(3);  check("b_jz_pc", pc, 8'h30); check("b_jz_addr", mem_addr, 8'h30);
    Reset = 1'b1;
    wr(8'h01, 16'h4022);
    go();
    step(12); check("b_sub_nz", acc, 16'h0002); check("b_z0", zflag, 0);
    step(3);  check("b_nojz_pc", pc, 8'h03); check("b_nojz_addr", mem_addr, 8'h03);

    Reset = 1'b1;
    wr(8'h00, 16'h80FF); wr(8'hFF, 16'h0000);
    go();
    step(3);  check("w_jump_pc", pc, 8'hFF); check("w_jump_addr", mem_addr, 8'hFF);
    step(2);  check("w_pc_wrap", pc, 8'h00);
    step(1);  check("w_fetch_00", mem_addr, 8'h00);

`ifdef CPU_DIV_EN
    Reset = 1'b1;
    wr(8'h00, 16'h1050); wr(8'h01, 16'hA051); wr(8'h02, 16'hF000);
    wr(8'h50, 16'h0064); wr(8'h51, 16'h0007); wr(8'h52, 16'h0000);
    go();
    l0 = loads;
    step(11); check("d_load", div_load, 1); check("d_a", div_a, 16'h0064); check("d_b", div_b, 16'h0007);
    step(1);  check("d_load_pulse", div_load, 0); check("d_stale_ignored", acc, 16'h0064);
    wait_halt(40);
    check("d_acc", acc, 16'h000E); check("d_z", zflag, 0); check("d_one_load", loads - l0, 1);

    Reset = 1'b1;
    wr(8'h01, 16'hA052);
    go();
    l0 = loads;
    step(11); check("z_no_load", div_load, 0);
    step(1);  check("z_acc", acc, 16'hFFFF); check("z_z", zflag, 0); check("z_fetch", mem_addr, 8'h02);
    wait_halt(10);
    check("z_loads", loads - l0, 0);

    Reset = 1'b1;
    wr(8'h01, 16'hA051);
    go();
    step(13);
    Reset = 1'b1;
    step(1);
    check("r_pc", pc, 8'h00); check("r_ir", ir, 16'h0000); check("r_acc", acc, 16'h0000);
    check("r_z", zflag, 0); check("r_divload", div_load, 0); check("r_halted", halted, 0);
    go();
    step(2);  check("r_refetch_ir", ir, 16'h1050); check("r_refetch_pc", pc, 8'h01);
    step(4);  check("r_reload", acc, 16'h0064);
`else
    Reset = 1'b1;
    wr(8'h00, 16'h1050); wr(8'h01, 16'hA051); wr(8'h02, 16'hF000);
    wr(8'h50, 16'h0064); wr(8'h51, 16'h0007);
    go();
    l0 = loads;
    step(9);  check("n_div_nop_acc", acc, 16'h0064); check("n_div_nop_pc", pc, 8'h02);
    check("n_div_a", div_a, 16'h0000);
    step(3);  check("n_halted", halted, 1); check("n_no_load", loads - l0, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
